qpsk_rr_sched: RTL and testbench
================================

QPSK_RR_SCHED -- requirements
Module: qpsk_rr_sched

Parameters
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning symbols per demapped character, legal range 1..15.
REQ-002 SHALL have parameter STALL_LIMIT, default 255, meaning max consecutive mid-burst starved cycles before stall_err sets, legal range 1..255.

Interface
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  permits new bursts to start.
REQ-006 SHALL have ports req0_empty/req1_empty  input  1 each  source FIFO empty.
REQ-007 SHALL have ports req0_rd_en/req1_rd_en  output  1 each  source FIFO read strobe; data is valid one cycle later.
REQ-008 SHALL have ports req0_sym_i, req0_sym_q, req1_sym_i, req1_sym_q  input  8 signed each  FIFO symbol data.
REQ-009 SHALL have ports sym_i, sym_q  output  8 signed each  symbol to demapper.
REQ-010 SHALL have port iq_valid  output  1  sym_i/sym_q valid to demapper.
REQ-011 SHALL have port grant_id  output  1  source of current/last burst.
REQ-012 SHALL have port busy  output  1  high while in BURST or DRAIN.
REQ-013 SHALL have port char_count  output  16  completed characters, wraps 0xFFFF->0.
REQ-014 SHALL have port stall_err  output  1  sticky starvation flag.

Function
REQ-015 SHALL implement FSM states IDLE, BURST and DRAIN.
REQ-016 IDLE: if en=1 and at least one requester is non-empty, SHALL latch grant_id and go to BURST next cycle; otherwise SHALL stay in IDLE.
REQ-017 Arbitration: both non-empty -> SHALL grant the requester opposite the last granted one; only one non-empty -> SHALL grant that requester.
REQ-018 BURST: SHALL drive the granted rd_en = !granted_empty while issued < BURST_LEN, and SHALL assert the non-granted rd_en never.
REQ-019 After the BURST_LEN-th rd_en, SHALL go to DRAIN; in DRAIN rd_en SHALL be 0 for one cycle, then the FSM SHALL return to IDLE.
REQ-020 Pipeline: rd_en at cycle t -> FIFO data at t+1 -> registered into sym_i/sym_q with iq_valid=1 at t+2; latency 2 cycles.
REQ-021 iq_valid SHALL be a single-cycle pulse per symbol; sym_i/sym_q SHALL hold their value when iq_valid=0.
REQ-022 A burst SHALL never be interleaved with the other source: exactly BURST_LEN iq_valid pulses per grant, keeping the demapper character-aligned.
REQ-023 Mid-burst empty: SHALL stall (no rd_en), keep the grant, and resume when non-empty; there SHALL be no abort.
REQ-024 Stall counter (8 bit): SHALL count consecutive starved BURST cycles and clear on any rd_en; on reaching STALL_LIMIT it SHALL set stall_err, which clears only on reset.
REQ-025 char_count SHALL increment by 1 in the cycle the BURST_LEN-th iq_valid of a burst is asserted.
REQ-026 en deasserted mid-burst SHALL NOT stop the burst; it SHALL only block the IDLE->BURST transition.
REQ-027 Minimum gap: the last rd_en of one burst to the first rd_en of the next SHALL be 3 cycles (DRAIN, IDLE, BURST).
REQ-028 Issued-symbol counter SHALL be 4 bits and reset to 0 on every IDLE->BURST transition.

Reset
REQ-029 On reset, outputs SHALL immediately be: rd_en=0, iq_valid=0, sym_i=sym_q=0, busy=0, char_count=0, stall_err=0, grant_id=0.
REQ-030 On reset, internal state SHALL be: FSM=IDLE, last-granted=1 (so req0 wins the first contention), counters=0.
REQ-031 Reset asserted mid-burst SHALL discard in-flight symbols; no iq_valid SHALL appear after reset deassertion until a new grant.

Verification
REQ-032 Both FIFOs loaded with 8 symbols, en=1 -> grants 0,1,0,1; each grant produces 4 iq_valid pulses; char_count=4.
REQ-033 req0 symbols (0x40,0x40),(0x40,0xC0),(0xC0,0x40),(0xC0,0xC0) -> same order on sym_i/sym_q, first iq_valid 2 cycles after first rd_en.
REQ-034 req1 empties after 2 symbols for 10 cycles, then refills -> no rd_en for 10 cycles, grant held, 4 pulses total, stall_err=0.
REQ-035 STALL_LIMIT=5, granted FIFO starved 5 cycles -> stall_err=1 and remains 1 after the burst completes.
REQ-036 en=0 after the first rd_en -> burst finishes (4 pulses), FSM stays IDLE while FIFOs remain non-empty.
REQ-037 Reset pulse after the 2nd rd_en -> outputs 0 in the same cycle, no stray iq_valid, next contention grants req0.

Source files
------------

// File: rtl/qpsk_rr_sched.sv
// Round-robin burst scheduler feeding QPSK symbols from two source FIFOs to a demapper.
// Each grant moves exactly BURST_LEN symbols so the demapper stays character-aligned.
module qpsk_rr_sched #(
  parameter int BURST_LEN   = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              req0_empty,
  input  logic              req1_empty,
  output logic              req0_rd_en,
  output logic              req1_rd_en,
  input  logic signed [7:0] req0_sym_i,
  input  logic signed [7:0] req0_sym_q,
  input  logic signed [7:0] req1_sym_i,
  input  logic signed [7:0] req1_sym_q,
  output logic signed [7:0] sym_i,
  output logic signed [7:0] sym_q,
  output logic              iq_valid,
  output logic              grant_id,
  output logic              busy,
  output logic [15:0]       char_count,
  output logic              stall_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [3:0] BURST_LEN_W   = 4'(BURST_LEN);
  localparam logic [7:0] STALL_LIMIT_W = 8'(STALL_LIMIT);

  logic [1:0] state;
  logic       last_grant;
  logic [3:0] issued;
  logic [7:0] stall_cnt;
  logic [3:0] out_cnt;
  logic       rd_d1;
  logic       src_d1;

  logic       granted_empty;
  logic       in_burst;
  logic       rd_any;
  logic       starved;
  logic       any_req;
  logic       next_grant;

  always_comb begin
    granted_empty = grant_id ? req1_empty : req0_empty;
    in_burst      = (state == BURST) && (issued < BURST_LEN_W);
    rd_any        = in_burst && !granted_empty;
    starved       = in_burst && granted_empty;
    any_req       = !req0_empty || !req1_empty;
    // Contention alternates; a lone requester wins outright (req0_empty=1 implies req1).
    if (!req0_empty && !req1_empty) begin
      next_grant = !last_grant;
    end else begin
      next_grant = req0_empty;
    end
  end

  assign req0_rd_en = rd_any && !grant_id;
  assign req1_rd_en = rd_any && grant_id;
  assign busy       = (state == BURST) || (state == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      issued     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && any_req) begin
            state      <= BURST;
            grant_id   <= next_grant;
            last_grant <= next_grant;
            issued     <= '0;
          end
        end
        BURST: begin
          if (rd_any) begin
            issued <= issued + 4'd1;
            if (issued == BURST_LEN_W - 4'd1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (rd_any) begin
      stall_cnt <= '0;
    end else if (starved) begin
      if (stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (stall_cnt >= STALL_LIMIT_W - 8'd1) begin
        stall_err <= 1'b1;
      end
    end
  end

  // Output stage: FIFO data arrives one cycle after rd_en and is registered here,
  // so out_cnt sees symbols in grant order and closes a character on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d1      <= 1'b0;
      src_d1     <= 1'b0;
      iq_valid   <= 1'b0;
      sym_i      <= '0;
      sym_q      <= '0;
      out_cnt    <= '0;
      char_count <= '0;
    end else begin
      rd_d1    <= rd_any;
      src_d1   <= grant_id;
      iq_valid <= rd_d1;
      if (rd_d1) begin
        sym_i <= src_d1 ? req1_sym_i : req0_sym_i;
        sym_q <= src_d1 ? req1_sym_q : req0_sym_q;
        if (out_cnt == BURST_LEN_W - 4'd1) begin
          out_cnt    <= '0;
          char_count <= char_count + 16'd1;
        end else begin
          out_cnt <= out_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_rr_sched.sv
// Directed bench for qpsk_rr_sched: two model FIFOs, a grant/symbol scoreboard and
// explicit checks of stall, enable, gap and mid-burst reset behaviour.
module tb_qpsk_rr_sched;

  localparam int BL = 4;
  localparam int SL = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              req0_empty;
  logic              req1_empty;
  logic              req0_rd_en;
  logic              req1_rd_en;
  logic signed [7:0] req0_sym_i = '0;
  logic signed [7:0] req0_sym_q = '0;
  logic signed [7:0] req1_sym_i = '0;
  logic signed [7:0] req1_sym_q = '0;
  logic signed [7:0] sym_i;
  logic signed [7:0] sym_q;
  logic              iq_valid;
  logic              grant_id;
  logic              busy;
  logic [15:0]       char_count;
  logic              stall_err;

  logic [7:0] m0i[64];
  logic [7:0] m0q[64];
  logic [7:0] m1i[64];
  logic [7:0] m1q[64];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

  int errors = 0, checks = 0;
  int cyc = 0, rd_total = 0, rib = 0, pcnt = 0;
  logic [15:0] exp_char = '0;
  logic [15:0] last_iq = '0;
  logic        cur_src = 1'b0;
  logic [16:0] exp_q[$];
  int          rd_t[$];
  int          rd_log[$];
  logic        gq[$];

  qpsk_rr_sched #(.BURST_LEN(BL), .STALL_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req0_empty(req0_empty), .req1_empty(req1_empty),
    .req0_rd_en(req0_rd_en), .req1_rd_en(req1_rd_en),
    .req0_sym_i(req0_sym_i), .req0_sym_q(req0_sym_q),
    .req1_sym_i(req1_sym_i), .req1_sym_q(req1_sym_q),
    .sym_i(sym_i), .sym_q(sym_q), .iq_valid(iq_valid),
    .grant_id(grant_id), .busy(busy), .char_count(char_count), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  assign req0_empty = (wr0 == rd0);
  assign req1_empty = (wr1 == rd1);

  // Source FIFOs: data for a read strobe appears after the sampling edge.
  always @(posedge clk) begin
    if (req0_rd_en) begin
      req0_sym_i <= m0i[rd0[5:0]];
      req0_sym_q <= m0q[rd0[5:0]];
      rd0 <= rd0 + 1;
    end
    if (req1_rd_en) begin
      req1_sym_i <= m1i[rd1[5:0]];
      req1_sym_q <= m1q[rd1[5:0]];
      rd1 <= rd1 + 1;
    end
  end

  function automatic logic [15:0] pat(input int s, input int k);
    pat = {8'(s * 64 + k * 7 + 3), 8'(240 - k * 5 - s * 32)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fpush(input int s, input logic [15:0] v);
    if (s == 0) begin
      m0i[wr0[5:0]] = v[15:8];
      m0q[wr0[5:0]] = v[7:0];
      wr0++;
    end else begin
      m1i[wr1[5:0]] = v[15:8];
      m1q[wr1[5:0]] = v[7:0];
      wr1++;
    end
  endtask

  task automatic exp_push(input logic s, input logic [15:0] v);
    exp_q.push_back({s, v});
  endtask

  task automatic flush();
    exp_q.delete();
    rd_t.delete();
    gq.delete();
    rib = 0;
    pcnt = 0;
    exp_char = '0;
    last_iq = '0;
  endtask

  // Observe the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    logic [16:0] e;
    int t;
    @(negedge clk);
    cyc++;
    if (req0_rd_en || req1_rd_en) begin
      if (rib == 0) begin
        chk("grant_expected", 32'(gq.size() != 0), 32'd1);
        if (gq.size() != 0) cur_src = gq.pop_front();
      end
      chk("rd_sel", 32'({req1_rd_en, req0_rd_en}), 32'(cur_src ? 2'b10 : 2'b01));
      rd_t.push_back(cyc);
      rd_log.push_back(cyc);
      rd_total++;
      rib = (rib == BL - 1) ? 0 : rib + 1;
    end
    if (iq_valid) begin
      chk("valid_expected", 32'(exp_q.size() != 0 && rd_t.size() != 0), 32'd1);
      if (exp_q.size() != 0 && rd_t.size() != 0) begin
        e = exp_q.pop_front();
        t = rd_t.pop_front();
        chk("sym", 32'({grant_id, sym_i, sym_q}), 32'(e));
        chk("latency", 32'(cyc - t), 32'd2);
        last_iq = e[15:0];
        pcnt++;
        if (pcnt == BL) begin
          pcnt = 0;
          exp_char = exp_char + 16'd1;
        end
        chk("char_count", 32'(char_count), 32'(exp_char));
      end
    end else begin
      chk("hold", 32'({sym_i, sym_q}), 32'(last_iq));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (rd_total < target && n < budget) begin
      tick();
      n++;
    end
    chk("rd_wait", 32'(rd_total >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int lb;
    reset = 1'b1;
    en    = 1'b0;
    #2;
    chk("rst_rd", 32'({req1_rd_en, req0_rd_en}), 32'd0);
    chk("rst_valid", 32'(iq_valid), 32'd0);
    chk("rst_sym", 32'({sym_i, sym_q}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_char", 32'(char_count), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Both sources loaded: grants alternate 0,1,0,1 starting with req0.
    en = 1'b1;
    lb = rd_log.size();
    for (int k = 0; k < 8; k++) begin
      fpush(0, pat(0, k));
      fpush(1, pat(1, k));
    end
    for (int b = 0; b < 4; b++) begin
      gq.push_back(1'(b % 2));
      for (int k = 0; k < BL; k++) exp_push(1'(b % 2), pat(b % 2, (b / 2) * BL + k));
    end
    wait_done(200);
    chk("char_after_rr", 32'(char_count), 32'd4);
    chk("burst_contig", 32'(rd_log[lb + 3] - rd_log[lb]), 32'd3);
    chk("min_gap", 32'(rd_log[lb + 4] - rd_log[lb + 3]), 32'd3);

    // Fixed constellation points from req0, order and latency preserved.
    gq.push_back(1'b0);
    fpush(0, 16'h4040); exp_push(1'b0, 16'h4040);
    fpush(0, 16'h40C0); exp_push(1'b0, 16'h40C0);
    fpush(0, 16'hC040); exp_push(1'b0, 16'hC040);
    fpush(0, 16'hC0C0); exp_push(1'b0, 16'hC0C0);
    wait_done(50);
    chk("char_after_pts", 32'(char_count), 32'd5);

    // req1 runs dry after two symbols for ten cycles; grant is held.
    gq.push_back(1'b1);
    fpush(1, pat(1, 20));
    fpush(1, pat(1, 21));
    for (int k = 20; k < 24; k++) exp_push(1'b1, pat(1, k));
    base = rd_total;
    wait_rd(base + 2, 50);
    for (int k = 0; k < 10; k++) begin
      chk("starve_rd", 32'({req1_rd_en, req0_rd_en}), 32'd0);
      chk("starve_grant", 32'(grant_id), 32'd1);
      tick();
    end
    fpush(1, pat(1, 22));
    fpush(1, pat(1, 23));
    wait_done(50);
    chk("stall_clear", 32'(stall_err), 32'd0);
    chk("char_after_starve", 32'(char_count), 32'd6);

    // en dropped after the first read: burst completes, then no new grant.
    gq.push_back(1'b0);
    for (int k = 30; k < 34; k++) begin
      fpush(0, pat(0, k));
      exp_push(1'b0, pat(0, k));
    end
    fpush(1, pat(1, 40));
    fpush(1, pat(1, 41));
    base = rd_total;
    wait_rd(base + 1, 50);
    en = 1'b0;
    wait_done(50);
    chk("char_after_en", 32'(char_count), 32'd7);
    for (int k = 0; k < 8; k++) begin
      chk("en_block_rd", 32'({req1_rd_en, req0_rd_en}), 32'd0);
      chk("en_block_busy", 32'(busy), 32'd0);
      tick();
    end

    // Starvation reaching STALL_LIMIT sets a sticky error.
    en = 1'b1;
    gq.push_back(1'b1);
    for (int k = 40; k < 44; k++) exp_push(1'b1, pat(1, k));
    base = rd_total;
    wait_rd(base + 2, 50);
    for (int k = 0; k < SL; k++) begin
      chk("stall_rd", 32'({req1_rd_en, req0_rd_en}), 32'd0);
      chk("stall_pre", 32'(stall_err), 32'd0);
      tick();
    end
    fpush(1, pat(1, 42));
    fpush(1, pat(1, 43));
    chk("stall_set", 32'(stall_err), 32'd1);
    wait_done(50);
    chk("stall_sticky", 32'(stall_err), 32'd1);
    chk("char_after_stall", 32'(char_count), 32'd8);

    // Reset mid-burst after the second read of a req1 burst.
    gq.push_back(1'b1);
    for (int k = 50; k < 54; k++) begin
      fpush(1, pat(1, k));
      exp_push(1'b1, pat(1, k));
    end
    base = rd_total;
    wait_rd(base + 2, 50);
    reset = 1'b1;
    #1;
    chk("mrst_rd", 32'({req1_rd_en, req0_rd_en}), 32'd0);
    chk("mrst_valid", 32'(iq_valid), 32'd0);
    chk("mrst_sym", 32'({sym_i, sym_q}), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_char", 32'(char_count), 32'd0);
    chk("mrst_stall", 32'(stall_err), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    flush();
    for (int k = 60; k < 64; k++) begin
      fpush(0, pat(0, k));
      exp_push(1'b0, pat(0, k));
    end
    fpush(1, pat(1, 54));
    fpush(1, pat(1, 55));
    for (int k = 52; k < 56; k++) exp_push(1'b1, pat(1, k));
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("no_stray", 32'(iq_valid), 32'd0);
      tick();
    end
    wait_done(100);
    chk("char_after_rst", 32'(char_count), 32'd2);
    chk("stall_after_rst", 32'(stall_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
